// File: rtl/btn_debounce_pulse_if.sv
// Button conditioner signal bundle: raw button level in, debounced level and strobes out.
// The master side drives the button; the slave side is the conditioner.
interface btn_debounce_pulse_if;
  logic btn_in;
  logic level_out;
  logic pulse_out;
  logic is_repeat;
  logic release_pulse;

  modport master (
    output btn_in,
    input  level_out,
    input  pulse_out,
    input  is_repeat,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output level_out,
    output pulse_out,
    output is_repeat,
    output release_pulse
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-FF synchronizer, counter debouncer, press/repeat strobe
// and release strobe. All outputs are registered.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  btn_debounce_pulse_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic               first_rep_q, first_rep_d;
  logic               level_q, level_d;
  logic               pulse_q, pulse_d;
  logic               is_repeat_q, is_repeat_d;
  logic               release_q, release_d;

  logic               btn_s;
  logic               cnt_done;
  logic               rep_hit;

  assign btn_s    = sync_q[1];
  assign cnt_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  // First repeat waits the long delay, later ones use the short period.
  assign rep_hit  = first_rep_q ? (rep_cnt_q == REP_W'(REPEAT_DELAY - 1))
                                : (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1));

  // State, counter, synchronizer and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b00;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rep_cnt_q   <= '0;
      first_rep_q <= 1'b1;
      level_q     <= 1'b0;
      pulse_q     <= 1'b0;
      is_repeat_q <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.btn_in};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      first_rep_q <= first_rep_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      is_repeat_q <= is_repeat_d;
      release_q   <= release_d;
    end
  end

  // Next-state and counter logic; counters clear on every state change
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rep_cnt_d   = rep_cnt_q;
    first_rep_d = first_rep_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d     = HELD;
          cnt_d       = '0;
          rep_cnt_d   = '0;
          first_rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d   = RELEASE_WAIT;
          cnt_d     = '0;
          rep_cnt_d = '0;
        end else if (REPEAT_EN) begin
          if (rep_hit) begin
            rep_cnt_d   = '0;
            first_rep_d = 1'b0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high resumes the hold and restarts the repeat delay.
        if (btn_s) begin
          state_d     = HELD;
          cnt_d       = '0;
          rep_cnt_d   = '0;
          first_rep_d = 1'b1;
        end else if (cnt_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-values, registered above
  always_comb begin
    level_d     = level_q;
    pulse_d     = 1'b0;
    is_repeat_d = 1'b0;
    release_d   = 1'b0;
    unique case (state_q)
      PRESS_WAIT: begin
        if (btn_s && cnt_done) begin
          level_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      HELD: begin
        if (btn_s && REPEAT_EN && rep_hit) begin
          pulse_d     = 1'b1;
          is_repeat_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!btn_s && cnt_done) begin
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      default: begin
        level_d = level_q;
      end
    endcase
  end

  assign bus.level_out     = level_q;
  assign bus.pulse_out     = pulse_q;
  assign bus.is_repeat     = is_repeat_q;
  assign bus.release_pulse = release_q;

endmodule
